// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between a framebuffer reader and VGA timing: circular storage feeding a
// show-ahead head register, with an optional flush and reader restart on each vblank rising edge.
module vga_pixel_fifo #(
  parameter int C_DEPTH_LOG2      = 4,
  parameter int C_FLUSH_ON_VBLANK = 1
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [23:0]             wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    frame_start,
  input  logic                    fetch_next,
  input  logic                    vblank,
  output logic [7:0]              r_o,
  output logic [7:0]              g_o,
  output logic [7:0]              b_o,
  output logic [C_DEPTH_LOG2+1:0] level,
  output logic                    underflow
);

  localparam int DEPTH = 2 ** C_DEPTH_LOG2;
  localparam logic [C_DEPTH_LOG2:0] FULL_COUNT = (C_DEPTH_LOG2 + 1)'(DEPTH);

  logic [23:0]             mem [0:DEPTH-1];
  logic [C_DEPTH_LOG2-1:0] wr_ptr;
  logic [C_DEPTH_LOG2-1:0] rd_ptr;
  logic [C_DEPTH_LOG2:0]   count;
  logic [23:0]             head;
  logic                    head_valid;
  logic                    vblank_q;
  logic                    in_reset;

  logic flush;
  logic fetch_ok;
  logic pop;
  logic wr_en;

  always_comb begin
    flush    = 1'b0;
    fetch_ok = 1'b0;
    pop      = 1'b0;
    wr_ready = 1'b0;
    wr_en    = 1'b0;
    if (C_FLUSH_ON_VBLANK != 0) begin
      flush = vblank && !vblank_q;
    end else begin
      flush = 1'b0;
    end
    fetch_ok = fetch_next && !flush;
    // Head refills whenever it is empty or being consumed, as long as storage has a word.
    pop      = (count != '0) && (!head_valid || fetch_ok) && !flush;
    wr_ready = (count < FULL_COUNT) && !reset && !flush;
    wr_en    = wr_valid && wr_ready;
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= 24'h000000;
      head_valid <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        head       <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (fetch_ok && head_valid) begin
        head_valid <= 1'b0;
      end
      // A consume request with nothing on display is latched until reset.
      if (fetch_ok && !head_valid) begin
        underflow <= 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // vblank_q resets high so a vblank already high at release is not taken as an edge.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      vblank_q    <= 1'b1;
      in_reset    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vblank_q    <= vblank;
      in_reset    <= 1'b0;
      frame_start <= flush || in_reset;
    end
  end

  assign r_o   = head[23:16];
  assign g_o   = head[15:8];
  assign b_o   = head[7:0];
  assign level = {1'b0, count} + {{(C_DEPTH_LOG2 + 1){1'b0}}, head_valid};

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo: a per-cycle vector table plus hand sequences for
// fill/full, order with stalls, underflow stickiness, vblank flush and the no-flush variant.
module tb_vga_pixel_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] wr_data = 24'h0;
  logic        wr_valid = 1'b0, fetch_next = 1'b0, vblank = 1'b0;
  logic        wr_ready, frame_start, underflow;
  logic [7:0]  r_o, g_o, b_o;
  logic [5:0]  level;

  logic        b_reset = 1'b1;
  logic [23:0] b_wr_data = 24'h0;
  logic        b_wr_valid = 1'b0, b_fetch_next = 1'b0, b_vblank = 1'b0;
  logic        b_wr_ready, b_frame_start, b_underflow;
  logic [7:0]  b_r, b_g, b_b;
  logic [5:0]  b_level;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_pixel_fifo #(.C_DEPTH_LOG2(4), .C_FLUSH_ON_VBLANK(1)) dut (
    .clk_pixel(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .frame_start(frame_start), .fetch_next(fetch_next),
    .vblank(vblank), .r_o(r_o), .g_o(g_o), .b_o(b_o), .level(level), .underflow(underflow));

  vga_pixel_fifo #(.C_DEPTH_LOG2(4), .C_FLUSH_ON_VBLANK(0)) dut_nf (
    .clk_pixel(clk), .reset(b_reset), .wr_data(b_wr_data), .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready), .frame_start(b_frame_start), .fetch_next(b_fetch_next),
    .vblank(b_vblank), .r_o(b_r), .g_o(b_g), .b_o(b_b), .level(b_level), .underflow(b_underflow));

  typedef struct {
    logic        rst, wv;
    logic [23:0] wd;
    logic        fn, vb;
    logic [23:0] e_rgb;
    logic [5:0]  e_lvl;
    logic        e_rdy, e_fs, e_uf;
  } vec_t;

  vec_t tbl [14];
  logic [23:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_valid = 1'b0; fetch_next = 1'b0; vblank = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //               rst   wv    wd          fn    vb    rgb         lvl   rdy   fs    uf
    tbl[0]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 24'h112233, 1'b0, 1'b0, 24'h000000, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h112233, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h112233, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h112233, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h112233, 6'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 24'hAABBCC, 1'b0, 1'b0, 24'h112233, 6'd0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 24'h010203, 1'b0, 1'b0, 24'h112233, 6'd1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 24'h445566, 1'b1, 1'b1, 24'hAABBCC, 6'd2, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hAABBCC, 6'd0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hAABBCC, 6'd0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hAABBCC, 6'd0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      fetch_next = tbl[i].fn; vblank = tbl[i].vb;
      #1;
      chk($sformatf("vec%0d_rgb", i), {r_o, g_o, b_o}, tbl[i].e_rgb);
      chk($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_frame_start", i), frame_start, tbl[i].e_fs);
      chk($sformatf("vec%0d_underflow", i), underflow, tbl[i].e_uf);
    end

    // Fill 17 words into depth 16 + head, then drain in order.
    do_reset();
    begin
      int n = 0;
      for (int c = 0; c < 100 && n < 17; c++) begin
        wr_valid = 1'b1; wr_data = 24'(n);
        #1;
        if (wr_ready) n++;
        @(negedge clk);
      end
      chk("fill17_count", n, 17);
    end
    wr_valid = 1'b1; wr_data = 24'h000099;
    #1;
    chk("full_level", level, 17);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_head", {r_o, g_o, b_o}, 0);
    @(negedge clk);
    wr_valid = 1'b0; fetch_next = 1'b1;
    #1;
    chk("full_offer_dropped", level, 17);
    @(negedge clk);
    fetch_next = 1'b0;
    #1;
    chk("after_fetch_head", {r_o, g_o, b_o}, 1);
    chk("after_fetch_wr_ready", wr_ready, 1);
    chk("after_fetch_level", level, 16);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain_word%0d", k), {r_o, g_o, b_o}, k);
      fetch_next = 1'b1;
      @(negedge clk);
      fetch_next = 1'b0;
      #1;
    end
    chk("drain_level", level, 0);
    chk("drain_no_underflow", underflow, 0);

    // Simultaneous write and fetch with five words stored, then random-stall ordering.
    do_reset();
    q.delete();
    for (int j = 0; j < 6; j++) begin
      wr_valid = 1'b1; wr_data = 24'(100 + j);
      #1;
      if (wr_ready) q.push_back(wr_data);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("cnt5_level", level, 6);
    wr_valid = 1'b1; wr_data = 24'd200; fetch_next = 1'b1;
    #1;
    if (wr_ready) q.push_back(wr_data);
    void'(q.pop_front());
    @(negedge clk);
    wr_valid = 1'b0; fetch_next = 1'b0;
    #1;
    chk("cnt5_level_kept", level, 6);
    chk("cnt5_head_advanced", {r_o, g_o, b_o}, 101);
    begin
      int sent = 0;
      for (int c = 0; c < 2000 && sent < 100; c++) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_data = 24'(1000 + sent);
        fetch_next = (level >= 6'd2) && ($urandom_range(0, 1) == 1);
        #1;
        if (wr_valid && wr_ready) begin
          q.push_back(wr_data);
          sent++;
        end
        if (fetch_next) begin
          chk("stall_order", {r_o, g_o, b_o}, q[0]);
          void'(q.pop_front());
        end
        @(negedge clk);
      end
      chk("stall_sent", sent, 100);
    end
    wr_valid = 1'b0; fetch_next = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 200 && q.size() > 0; g++) begin
      chk("stall_drain_order", {r_o, g_o, b_o}, q[0]);
      void'(q.pop_front());
      fetch_next = 1'b1;
      @(negedge clk);
      fetch_next = 1'b0;
    end
    #1;
    chk("stall_final_level", level, 0);
    chk("stall_no_underflow", underflow, 0);

    // Underflow stays set through writes and a flush.
    do_reset();
    fetch_next = 1'b1;
    @(negedge clk);
    fetch_next = 1'b0;
    chk("uf_set", underflow, 1);
    for (int j = 0; j < 3; j++) begin
      wr_valid = 1'b1; wr_data = 24'(j + 7);
      @(negedge clk);
    end
    wr_valid = 1'b0; vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
    chk("uf_sticky_after_flush", underflow, 1);
    chk("uf_flush_level", level, 0);

    // Flush at level 9 with a write and fetch offered in the edge cycle.
    do_reset();
    for (int j = 0; j < 9; j++) begin
      wr_valid = 1'b1; wr_data = 24'(50 + j);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_flush_level", level, 9);
    vblank = 1'b1; wr_valid = 1'b1; wr_data = 24'hDEADBE; fetch_next = 1'b1;
    #1;
    chk("flush_wr_ready", wr_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0; fetch_next = 1'b0;
    #1;
    chk("flush_level", level, 0);
    chk("flush_underflow", underflow, 0);
    chk("flush_frame_start", frame_start, 1);
    @(negedge clk);
    #1;
    chk("flush_fs_one_cycle", frame_start, 0);
    chk("flush_write_discarded", level, 0);
    vblank = 1'b0;

    // Variant without flush: vblank toggles leave contents alone.
    @(negedge clk);
    b_reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      b_wr_valid = 1'b1; b_wr_data = 24'(j + 1);
      @(negedge clk);
    end
    b_wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("nf_level_before", b_level, 4);
    for (int j = 0; j < 6; j++) begin
      b_vblank = (j < 3);
      @(negedge clk);
      chk($sformatf("nf_fs_%0d", j), b_frame_start, 0);
      chk($sformatf("nf_level_%0d", j), b_level, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 SHALL have parameter C_DEPTH_LOG2, default 4, FIFO storage depth = 2**C_DEPTH_LOG2 entries.
REQ-002 SHALL have parameter C_FLUSH_ON_VBLANK, default 1; 1 = flush and restart on each vblank rising edge, 0 = never flush.
REQ-003 SHALL have port clk_pixel  in  1  pixel clock; sole clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_data  in  24  pixel {R[23:16],G[15:8],B[7:0]} from framebuffer reader.
REQ-006 SHALL have port wr_valid  in  1  wr_data valid.
REQ-007 SHALL have port wr_ready  out  1  FIFO can accept a word this cycle.
REQ-008 SHALL have port frame_start  out  1  one-cycle pulse telling reader to restart at frame pixel 0.
REQ-009 SHALL have port fetch_next  in  1  one-cycle pulse from VGA timing stage: current pixel consumed.
REQ-010 SHALL have port vblank  in  1  vertical blank level from VGA timing stage.
REQ-011 SHALL have ports r_o, g_o, b_o  out  8 each  current pixel, present ahead of fetch_next.
REQ-012 SHALL have port level  out  C_DEPTH_LOG2+2  words held (storage plus head register).
REQ-013 SHALL have port underflow  out  1  sticky: fetch_next seen with no valid pixel.

Function
REQ-014 SHALL hold words in a 2**C_DEPTH_LOG2-entry circular buffer; read/write pointers C_DEPTH_LOG2 bits, wrapping modulo depth.
REQ-015 SHALL drive wr_ready combinationally = (storage count < depth) and not reset and not flush cycle.
REQ-016 SHALL accept a write iff wr_valid and wr_ready in the same cycle; word visible to head no earlier than the next cycle.
REQ-017 SHALL keep a show-ahead head register (head, head_valid); r_o/g_o/b_o = head fields continuously, no combinational path from wr_data.
REQ-018 SHALL load head from storage one cycle after storage becomes non-empty while head_valid=0.
REQ-019 SHALL on fetch_next with head_valid=1 replace head with next stored word in that same edge if storage non-empty, else clear head_valid.
REQ-020 SHALL on fetch_next with head_valid=0 set underflow=1, keep head contents, and change no pointer.
REQ-021 SHALL update storage count: +1 on accepted write, -1 on pop to head, unchanged when both occur in one cycle.
REQ-022 SHALL never drop or duplicate a word; output order equals accepted write order.
REQ-023 SHALL register vblank once and detect a rising edge (vblank=1, previous=0).
REQ-024 SHALL, when C_FLUSH_ON_VBLANK=1, in the edge-detect cycle clear pointers, count and head_valid, deassert wr_ready and discard any write offered that cycle.
REQ-025 SHALL assert frame_start for exactly one cycle, the cycle after a flush, and one cycle after reset release.
REQ-026 SHALL ignore fetch_next in the flush cycle (no pop, no underflow).
REQ-027 SHALL keep underflow sticky until reset; flush does not clear it.
REQ-028 SHALL drive level = storage count + head_valid, registered-state derived, max depth+1.

Reset
REQ-029 SHALL while reset=1 force pointers, count, head_valid=0, head=0 (r_o=g_o=b_o=0), underflow=0, level=0, wr_ready=0, frame_start=0, registered vblank=1 (no flush edge on first cycle after reset).
REQ-030 SHALL honour reset asserted mid-frame or mid-write by discarding all held data at that edge.

Verification
REQ-031 Reset release, write 0x112233 -> frame_start=1 in cycle 1 after release; r_o=0x11,g_o=0x22,b_o=0x33 with level=1 within 2 cycles of write acceptance.
REQ-032 Write 17 words 0..16 with depth 16, no fetch -> head=0, storage full, wr_ready=0, level=17; one fetch_next -> head=1, wr_ready=1 next cycle.
REQ-033 Simultaneous write and fetch_next with storage count 5 -> count stays 5, head advances one word, order preserved over 100 random-stall words.
REQ-034 fetch_next with level=0 -> underflow=1 and stays 1 after 3 further writes and a vblank flush.
REQ-035 level=9, vblank 0->1 with wr_valid=1 and fetch_next=1 -> next cycle level=0, underflow unchanged, write discarded; following cycle frame_start=1 for one cycle.
REQ-036 C_FLUSH_ON_VBLANK=0, vblank toggled with level=4 -> level stays 4, no frame_start pulse.
